// File: rtl/ssio_ddr_tx_pkg.sv
// ssio_ddr_tx_pkg: shared types and sizing for the DDR/SDR transmit serializer
package ssio_ddr_tx_pkg;
    localparam int width_lp = 4;
    localparam int ifg_lp = 12;
    localparam int gap_w_lp = $clog2(ifg_lp + 1);
    typedef struct packed {
        logic                    last;
        logic [2*width_lp-1:0]   data;
    } entry_s;
    typedef enum logic {e_phase_lo, e_phase_hi} phase_e;
endpackage

// File: rtl/ssio_ddr_tx_fifo.sv
// ssio_ddr_tx_fifo: 2-entry ready/valid buffer in front of the output stage
module ssio_ddr_tx_fifo
    import ssio_ddr_tx_pkg::*;
#(
    parameter type entry_t = entry_s
)(
    input  logic   clk_i,
    input  logic   reset_i,
    input  entry_t data_i,
    input  logic   v_i,
    output logic   ready_o,
    output entry_t data_o,
    output logic   v_o,
    input  logic   yumi_i
);
    entry_t mem [2];
    logic wptr, rptr, push, pop;
    logic [1:0] count;
    assign ready_o = !reset_i && count != 2'd2;
    assign v_o = count != 2'd0;
    assign data_o = mem[rptr];
    assign push = v_i && ready_o;
    assign pop = yumi_i && v_o;
    // pointer/count update; storage is left unreset since count gates validity
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= data_i;
                wptr <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/ssio_ddr_tx_serializer.sv
// ssio_ddr_tx_serializer: turns buffered words into registered q1/q2/ctl lanes for an ODDR phy
module ssio_ddr_tx_serializer
    import ssio_ddr_tx_pkg::*;
#(
    parameter int                 width_p = width_lp,
    parameter logic [width_p-1:0] idle_p  = '0,
    parameter int                 ifg_p   = ifg_lp
)(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [2*width_p-1:0] data_i,
    input  logic                 last_i,
    input  logic                 v_i,
    output logic                 ready_o,
    input  logic                 sdr_mode_i,
    output logic [width_p-1:0]   output_q1_o,
    output logic [width_p-1:0]   output_q2_o,
    output logic                 output_ctl_o,
    output logic                 busy_o
);
    entry_s in_entry, head;
    logic head_v, pop;
    logic [width_p-1:0] lo, hi;
    phase_e phase;
    logic [gap_w_lp-1:0] gap;
    assign in_entry = '{last: last_i, data: data_i};
    ssio_ddr_tx_fifo #(.entry_t(entry_s)) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (in_entry),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (head),
        .v_o     (head_v),
        .yumi_i  (pop)
    );
    assign lo = head.data[width_p-1:0];
    assign hi = head.data[2*width_p-1:width_p];
    // the head leaves the buffer once its upper half has been driven
    assign pop = gap == '0 && head_v && (phase == e_phase_hi || !sdr_mode_i);
    assign busy_o = head_v || phase == e_phase_hi || gap != '0;
    // output stage: inter-frame gap wins, else DDR word or one SDR half per cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            output_q1_o <= idle_p;
            output_q2_o <= idle_p;
            output_ctl_o <= 1'b0;
            phase <= e_phase_lo;
            gap <= '0;
        end else if (gap != '0) begin
            output_q1_o <= idle_p;
            output_q2_o <= idle_p;
            output_ctl_o <= 1'b0;
            gap <= gap - 1'b1;
        end else if (head_v) begin
            output_q1_o <= phase == e_phase_hi ? hi : lo;
            output_q2_o <= phase == e_phase_hi ? hi : (sdr_mode_i ? lo : hi);
            output_ctl_o <= 1'b1;
            phase <= phase == e_phase_lo && sdr_mode_i ? e_phase_hi : e_phase_lo;
            if (pop && head.last) gap <= gap_w_lp'(ifg_p);
        end else begin
            output_q1_o <= idle_p;
            output_q2_o <= idle_p;
            output_ctl_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ssio_ddr_tx_serializer.sv
// tb_ssio_ddr_tx_serializer: directed table, burst/gap sequence and random run against a beat-queue model
module tb_ssio_ddr_tx_serializer;
    localparam int ifg = 12;
    logic clk = 1'b0;
    logic reset = 1'b1, last = 1'b0, v = 1'b0, sdr = 1'b0;
    logic [7:0] data = 8'h00;
    logic ready, ctl, busy;
    logic [3:0] q1, q2;
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    ssio_ddr_tx_serializer #(.width_p(4), .idle_p(4'h0), .ifg_p(ifg)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .data_i       (data),
        .last_i       (last),
        .v_i          (v),
        .ready_o      (ready),
        .sdr_mode_i   (sdr),
        .output_q1_o  (q1),
        .output_q2_o  (q2),
        .output_ctl_o (ctl),
        .busy_o       (busy)
    );

    // reference: buffered words, and the queue of output beats a started word expands into
    typedef struct {logic [3:0] q1, q2; logic ctl; bit pop;} beat_t;
    typedef struct {logic [7:0] data; logic last;} word_t;
    word_t wq[$];
    beat_t beats[$];
    logic [3:0] m_q1 = 0, m_q2 = 0;
    logic m_ctl = 0, m_rst = 1;

    task automatic model_step(input logic r, input logic mv, input logic [7:0] d, input logic ml, input logic ms);
        bit can_push;
        beat_t b;
        m_rst = r;
        if (r) begin
            wq.delete();
            beats.delete();
            m_q1 = 0; m_q2 = 0; m_ctl = 0;
            return;
        end
        can_push = wq.size() < 2;
        if (beats.size() == 0 && wq.size() > 0) begin
            if (ms) begin
                beats.push_back('{wq[0].data[3:0], wq[0].data[3:0], 1'b1, 1'b0});
                beats.push_back('{wq[0].data[7:4], wq[0].data[7:4], 1'b1, 1'b1});
            end else
                beats.push_back('{wq[0].data[3:0], wq[0].data[7:4], 1'b1, 1'b1});
            if (wq[0].last) for (int k = 0; k < ifg; k++) beats.push_back('{4'h0, 4'h0, 1'b0, 1'b0});
        end
        if (beats.size() > 0) begin
            b = beats.pop_front();
            m_q1 = b.q1; m_q2 = b.q2; m_ctl = b.ctl;
            if (b.pop) void'(wq.pop_front());
        end else begin
            m_q1 = 0; m_q2 = 0; m_ctl = 0;
        end
        if (mv && can_push) wq.push_back('{d, ml});
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic r, input logic cv, input logic [7:0] d, input logic cl, input logic cs);
        reset = r; v = cv; data = d; last = cl; sdr = cs;
        model_step(r, cv, d, cl, cs);
        @(posedge clk);
        #1;
    endtask

    typedef struct {logic r, v; logic [7:0] d; logic l, s; logic [3:0] q1, q2; logic ctl, rdy, busy;} vec_t;
    vec_t vecs[$];
    logic [7:0] bw [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    task automatic add(input logic r, cv, input logic [7:0] d, input logic l, s, input logic [3:0] e1, e2, input logic ec, er, eb);
        vecs.push_back('{r, cv, d, l, s, e1, e2, ec, er, eb});
    endtask

    initial begin
        // reset, then DDR 0xA5
        add(1,0,8'h00,0,0, 4'h0,4'h0,0,0,0);
        add(0,1,8'hA5,0,0, 4'h0,4'h0,0,1,1);
        add(0,0,8'h00,0,0, 4'h5,4'hA,1,1,0);
        add(0,0,8'h00,0,0, 4'h0,4'h0,0,1,0);
        // SDR 0x3C
        add(0,1,8'h3C,0,1, 4'h0,4'h0,0,1,1);
        add(0,0,8'h00,0,1, 4'hC,4'hC,1,1,1);
        add(0,0,8'h00,0,1, 4'h3,4'h3,1,1,0);
        add(0,0,8'h00,0,1, 4'h0,4'h0,0,1,0);
        // SDR back-pressure: ready drops with two queued, one handshake per two cycles
        add(0,1,8'h3C,0,1, 4'h0,4'h0,0,1,1);
        add(0,1,8'h5A,0,1, 4'hC,4'hC,1,0,1);
        add(0,1,8'h77,0,1, 4'h3,4'h3,1,1,1);
        add(0,1,8'h77,0,1, 4'hA,4'hA,1,0,1);
        add(0,0,8'h00,0,1, 4'h5,4'h5,1,1,1);
        add(0,0,8'h00,0,1, 4'h7,4'h7,1,1,1);
        add(0,0,8'h00,0,1, 4'h7,4'h7,1,1,0);
        // mode change during SDR phase 1 only applies to the next word
        add(0,1,8'hF0,0,1, 4'h0,4'h0,0,1,1);
        add(0,0,8'h00,0,1, 4'h0,4'h0,1,1,1);
        add(0,1,8'h12,0,0, 4'hF,4'hF,1,1,1);
        add(0,0,8'h00,0,1, 4'h2,4'h2,1,1,1);
        add(0,0,8'h00,0,0, 4'h1,4'h1,1,1,0);
        add(0,1,8'h34,0,0, 4'h0,4'h0,0,1,1);
        add(0,0,8'h00,0,0, 4'h4,4'h3,1,1,0);
        // reset with two words buffered and gap = 5
        add(0,1,8'h99,1,0, 4'h0,4'h0,0,1,1);
        add(0,1,8'h21,0,0, 4'h9,4'h9,1,1,1);
        add(0,1,8'h43,0,0, 4'h0,4'h0,0,0,1);
        for (int k = 0; k < 6; k++) add(0,0,8'h00,0,0, 4'h0,4'h0,0,0,1);
        add(1,0,8'h00,0,0, 4'h0,4'h0,0,0,0);
        add(0,0,8'h00,0,0, 4'h0,4'h0,0,1,0);
        add(0,0,8'h00,0,0, 4'h0,4'h0,0,1,0);
        add(0,0,8'h00,0,0, 4'h0,4'h0,0,1,0);
        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s);
            chk($sformatf("vec%0d q1", i), 8'(q1), 8'(vecs[i].q1));
            chk($sformatf("vec%0d q2", i), 8'(q2), 8'(vecs[i].q2));
            chk($sformatf("vec%0d ctl", i), 8'(ctl), 8'(vecs[i].ctl));
            chk($sformatf("vec%0d ready", i), 8'(ready), 8'(vecs[i].rdy));
            chk($sformatf("vec%0d busy", i), 8'(busy), 8'(vecs[i].busy));
        end
        // DDR burst ending in last, then exactly ifg idle cycles before the queued word
        cyc(0, 1, bw[0], 0, 0);
        chk("burst ready0", 8'(ready), 8'd1);
        chk("burst ctl0", 8'(ctl), 8'd0);
        for (int i = 1; i < 5; i++) begin
            cyc(0, 1, bw[i], i == 3, 0);
            chk($sformatf("burst ready%0d", i), 8'(ready), 8'd1);
            chk($sformatf("burst ctl%0d", i), 8'(ctl), 8'd1);
            chk($sformatf("burst q1_%0d", i), 8'(q1), 8'(bw[i-1][3:0]));
            chk($sformatf("burst q2_%0d", i), 8'(q2), 8'(bw[i-1][7:4]));
        end
        for (int i = 0; i < ifg; i++) begin
            cyc(0, 0, 8'h00, 0, 0);
            chk($sformatf("gap idle%0d", i), {3'b0, ctl, q1}, 8'h00);
        end
        cyc(0, 0, 8'h00, 0, 0);
        chk("after gap", {3'b0, ctl, q2, q1[3:1]}, {3'b0, 1'b1, 4'h5, 3'b010});
        cyc(0, 0, 8'h00, 0, 0);
        chk("after gap busy", 8'(busy), 8'd0);
        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) sdr = ~sdr;
            cyc($urandom_range(63) == 0, $urandom_range(3) != 0, 8'($urandom), $urandom_range(7) == 0, sdr);
            chk($sformatf("rnd%0d q", i), {q2, q1}, {m_q2, m_q1});
            chk($sformatf("rnd%0d ctl", i), 8'(ctl), 8'(m_ctl));
            chk($sformatf("rnd%0d ready", i), 8'(ready), 8'(!m_rst && wq.size() < 2));
            chk($sformatf("rnd%0d busy", i), 8'(busy), 8'(wq.size() > 0 || beats.size() > 0));
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
